// File: rtl/led_ring_decoder.sv
// LED ring decoder: tracks a left-rotating one-hot pattern on an 8-bit LED bus,
// counts completed laps (7->0 wraps) and flags malformed or out-of-order samples.
//
//   state  | meaning
//   SEARCH | no valid position known; waiting for a one-hot sample
//   TRACK  | locked onto the ring; pos holds the last lit index
module led_ring_decoder #(
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       led_in,
  input  logic             sample_en,
  input  logic             clr,
  output logic [2:0]       pos,
  output logic             pos_valid,
  output logic [CNT_W-1:0] lap_count,
  output logic             err_onehot,
  output logic             err_seq,
  output logic [CNT_W-1:0] err_count
);

  typedef enum logic {
    SEARCH = 1'b0,
    TRACK  = 1'b1
  } state_t;

  state_t           r_state;
  logic [2:0]       r_pos;
  logic             r_pos_valid;
  logic [CNT_W-1:0] r_lap_count;
  logic             r_err_onehot;
  logic             r_err_seq;
  logic [CNT_W-1:0] r_err_count;

  logic       w_onehot;
  logic [2:0] w_idx;
  logic [2:0] w_pos_next;
  logic       w_step;
  logic       w_lap_inc;
  logic       w_err_onehot;
  logic       w_err_seq;
  logic       w_err_inc;

  // Exactly one bit set: nonzero and clearing the lowest set bit leaves nothing.
  assign w_onehot = (led_in != 8'h00) && ((led_in & (led_in - 8'd1)) == 8'h00);

  // Index of the lit bit; only meaningful when w_onehot is high.
  always_comb begin
    w_idx = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (led_in[i]) w_idx = 3'(i);
    end
  end

  // 3-bit add wraps 7 -> 0, matching the ring rotation.
  assign w_pos_next   = r_pos + 3'd1;
  assign w_step       = (w_idx == w_pos_next);
  assign w_lap_inc    = sample_en && (r_state == TRACK) && w_onehot && w_step && (r_pos == 3'd7);
  assign w_err_onehot = sample_en && !w_onehot;
  assign w_err_seq    = sample_en && (r_state == TRACK) && w_onehot && !w_step && (w_idx != r_pos);
  assign w_err_inc    = w_err_onehot || w_err_seq;

  // FSM, position tracking, error pulses and saturating counters.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= SEARCH;
      r_pos        <= 3'd0;
      r_pos_valid  <= 1'b0;
      r_lap_count  <= '0;
      r_err_onehot <= 1'b0;
      r_err_seq    <= 1'b0;
      r_err_count  <= '0;
    end else begin
      r_err_onehot <= w_err_onehot;
      r_err_seq    <= w_err_seq;

      if (sample_en) begin
        if (!w_onehot) begin
          // Lose lock but keep the last position visible for debug.
          r_state     <= SEARCH;
          r_pos_valid <= 1'b0;
        end else begin
          // Legal step, stall and resync all end up at the sampled index.
          r_state     <= TRACK;
          r_pos_valid <= 1'b1;
          r_pos       <= w_idx;
        end
      end

      if (clr) begin
        r_lap_count <= '0;
        r_err_count <= '0;
      end else begin
        if (w_lap_inc && (r_lap_count != '1)) r_lap_count <= r_lap_count + CNT_W'(1);
        if (w_err_inc && (r_err_count != '1)) r_err_count <= r_err_count + CNT_W'(1);
      end
    end
  end

  assign pos        = r_pos;
  assign pos_valid  = r_pos_valid;
  assign lap_count  = r_lap_count;
  assign err_onehot = r_err_onehot;
  assign err_seq    = r_err_seq;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_led_ring_decoder.sv
// Self-checking bench for led_ring_decoder: directed scenarios plus a
// randomized run against a behavioural model of the ring rules.
module tb_led_ring_decoder;
  localparam int CNT_W = 8;
  localparam int CMAX  = (1 << CNT_W) - 1;

  logic             clk = 1'b0;
  logic             rst = 1'b0;
  logic [7:0]       led_in = 8'h00;
  logic             sample_en = 1'b0;
  logic             clr = 1'b0;
  logic [2:0]       pos;
  logic             pos_valid;
  logic [CNT_W-1:0] lap_count;
  logic             err_onehot;
  logic             err_seq;
  logic [CNT_W-1:0] err_count;

  int checks = 0;
  int errors = 0;

  // Behavioural model state
  int m_pos = 0;
  bit m_track = 0;
  int m_lap = 0;
  int m_err = 0;
  bit m_eoh = 0;
  bit m_eseq = 0;

  led_ring_decoder #(.CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst), .led_in(led_in), .sample_en(sample_en), .clr(clr),
    .pos(pos), .pos_valid(pos_valid), .lap_count(lap_count),
    .err_onehot(err_onehot), .err_seq(err_seq), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic model_step(input bit a_rst, input bit a_en, input bit a_clr, input logic [7:0] a_led);
    int idx;
    bit lap_inc;
    bit err_inc;
    if (a_rst) begin
      m_pos = 0; m_track = 0; m_lap = 0; m_err = 0; m_eoh = 0; m_eseq = 0;
      return;
    end
    m_eoh = 0; m_eseq = 0; lap_inc = 0;
    if (a_en) begin
      if ($countones(a_led) != 1) begin
        m_eoh = 1;
        m_track = 0;
      end else begin
        idx = 0;
        for (int i = 0; i < 8; i++) if (a_led[i]) idx = i;
        if (!m_track) begin
          m_track = 1;
          m_pos = idx;
        end else if (idx == (m_pos + 1) % 8) begin
          if (m_pos == 7) lap_inc = 1;
          m_pos = idx;
        end else if (idx != m_pos) begin
          m_eseq = 1;
          m_pos = idx;
        end
      end
    end
    err_inc = m_eoh || m_eseq;
    if (a_clr) begin
      m_lap = 0; m_err = 0;
    end else begin
      if (lap_inc && m_lap < CMAX) m_lap++;
      if (err_inc && m_err < CMAX) m_err++;
    end
  endtask

  // Drive one cycle, advance the model at the edge, return 1 time unit later.
  task automatic apply(input bit a_rst, input bit a_en, input bit a_clr, input logic [7:0] a_led);
    rst = a_rst; sample_en = a_en; clr = a_clr; led_in = a_led;
    @(posedge clk);
    model_step(a_rst, a_en, a_clr, a_led);
    #1;
    rst = 0; sample_en = 0; clr = 0;
  endtask

  task automatic test_reset();
    apply(1, 0, 0, 8'h00);
    checks++;
    if (pos !== 3'd0 || pos_valid !== 1'b0 || lap_count !== '0 || err_count !== '0 ||
        err_onehot !== 1'b0 || err_seq !== 1'b0) begin
      errors++;
      $display("FAIL reset: pos=%0d valid=%0b lap=%0d err=%0d eoh=%0b eseq=%0b expected all 0",
               pos, pos_valid, lap_count, err_count, err_onehot, err_seq);
    end
  endtask

  task automatic test_full_lap();
    logic [7:0] v;
    apply(1, 0, 0, 8'h00);
    v = 8'h01;
    for (int k = 0; k < 9; k++) begin
      apply(0, 1, 0, v);
      checks++;
      if (pos_valid !== 1'b1 || pos !== 3'(k % 8)) begin
        errors++;
        $display("FAIL full_lap step %0d: pos=%0d valid=%0b expected pos=%0d valid=1", k, pos, pos_valid, k % 8);
      end
      v = {v[6:0], v[7]};
    end
    checks++;
    if (lap_count !== 8'd1 || err_count !== 8'd0) begin
      errors++;
      $display("FAIL full_lap counts: lap=%0d err=%0d expected lap=1 err=0", lap_count, err_count);
    end
  endtask

  task automatic test_seq_err();
    apply(1, 0, 0, 8'h00);
    apply(0, 1, 0, 8'h04);
    apply(0, 1, 0, 8'h08);
    checks++;
    if (pos !== 3'd3 || err_seq !== 1'b0) begin
      errors++;
      $display("FAIL seq_err step: pos=%0d eseq=%0b expected pos=3 eseq=0", pos, err_seq);
    end
    apply(0, 1, 0, 8'h40);
    checks++;
    if (err_seq !== 1'b1 || err_onehot !== 1'b0 || pos !== 3'd6 || err_count !== 8'd1 || pos_valid !== 1'b1) begin
      errors++;
      $display("FAIL seq_err jump: eseq=%0b eoh=%0b pos=%0d err=%0d valid=%0b expected 1 0 6 1 1",
               err_seq, err_onehot, pos, err_count, pos_valid);
    end
    apply(0, 0, 0, 8'h40);
    checks++;
    if (err_seq !== 1'b0) begin
      errors++;
      $display("FAIL seq_err pulse width: eseq=%0b expected 0", err_seq);
    end
  endtask

  task automatic test_onehot_err();
    apply(1, 0, 0, 8'h00);
    apply(0, 1, 0, 8'h20);
    apply(0, 1, 0, 8'h24);
    checks++;
    if (err_onehot !== 1'b1 || err_seq !== 1'b0 || pos_valid !== 1'b0 || pos !== 3'd5 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL onehot_err: eoh=%0b eseq=%0b valid=%0b pos=%0d err=%0d expected 1 0 0 5 1",
               err_onehot, err_seq, pos_valid, pos, err_count);
    end
    apply(0, 1, 0, 8'h80);
    checks++;
    if (pos !== 3'd7 || pos_valid !== 1'b1 || err_onehot !== 1'b0 || err_seq !== 1'b0 || err_count !== 8'd1) begin
      errors++;
      $display("FAIL onehot_recover: pos=%0d valid=%0b eoh=%0b eseq=%0b err=%0d expected 7 1 0 0 1",
               pos, pos_valid, err_onehot, err_seq, err_count);
    end
  endtask

  task automatic test_stall();
    apply(1, 0, 0, 8'h00);
    apply(0, 1, 0, 8'h10);
    for (int k = 0; k < 3; k++) begin
      apply(0, 0, 0, 8'h10);
      apply(0, 1, 0, 8'h10);
      checks++;
      if (pos !== 3'd4 || pos_valid !== 1'b1 || err_onehot !== 1'b0 || err_seq !== 1'b0 ||
          lap_count !== 8'd0 || err_count !== 8'd0) begin
        errors++;
        $display("FAIL stall %0d: pos=%0d valid=%0b eoh=%0b eseq=%0b lap=%0d err=%0d expected 4 1 0 0 0 0",
                 k, pos, pos_valid, err_onehot, err_seq, lap_count, err_count);
      end
    end
  endtask

  task automatic test_saturate();
    logic [7:0] v;
    apply(1, 0, 0, 8'h00);
    apply(0, 1, 0, 8'h01);
    for (int lap = 0; lap < 300; lap++) begin
      v = 8'h02;
      for (int k = 0; k < 8; k++) begin
        apply(0, 1, 0, v);
        v = {v[6:0], v[7]};
      end
    end
    checks++;
    if (lap_count !== 8'd255 || pos !== 3'd0) begin
      errors++;
      $display("FAIL lap_saturate: lap=%0d pos=%0d expected lap=255 pos=0", lap_count, pos);
    end
    v = 8'h02;
    for (int k = 0; k < 7; k++) begin
      apply(0, 1, 0, v);
      v = {v[6:0], v[7]};
    end
    apply(0, 1, 1, 8'h01);
    checks++;
    if (lap_count !== 8'd0 || pos !== 3'd0 || pos_valid !== 1'b1) begin
      errors++;
      $display("FAIL clr_vs_wrap: lap=%0d pos=%0d valid=%0b expected 0 0 1", lap_count, pos, pos_valid);
    end
    apply(1, 0, 0, 8'h00);
    for (int k = 0; k < 260; k++) apply(0, 1, 0, 8'h00);
    checks++;
    if (err_count !== 8'd255) begin
      errors++;
      $display("FAIL err_saturate: err=%0d expected 255", err_count);
    end
    apply(0, 1, 1, 8'h03);
    checks++;
    if (err_count !== 8'd0 || err_onehot !== 1'b1) begin
      errors++;
      $display("FAIL clr_vs_err: err=%0d eoh=%0b expected err=0 eoh=1", err_count, err_onehot);
    end
  endtask

  task automatic test_rst_priority();
    apply(1, 0, 0, 8'h00);
    apply(0, 1, 0, 8'h02);
    apply(0, 1, 0, 8'h04);
    apply(1, 1, 1, 8'h00);
    checks++;
    if (err_onehot !== 1'b0 || err_count !== 8'd0 || pos_valid !== 1'b0 || pos !== 3'd0) begin
      errors++;
      $display("FAIL rst_priority: eoh=%0b err=%0d valid=%0b pos=%0d expected 0 0 0 0",
               err_onehot, err_count, pos_valid, pos);
    end
    apply(0, 1, 0, 8'h40);
    checks++;
    if (err_seq !== 1'b0 || pos !== 3'd6 || pos_valid !== 1'b1) begin
      errors++;
      $display("FAIL rst_then_search: eseq=%0b pos=%0d valid=%0b expected 0 6 1", err_seq, pos, pos_valid);
    end
  endtask

  task automatic test_random();
    logic [7:0] v;
    int r;
    bit a_rst, a_en, a_clr;
    apply(1, 0, 0, 8'h00);
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      v = 8'(1 << ((m_pos + 1) % 8));
      else if (r < 70) v = 8'(1 << m_pos);
      else if (r < 85) v = 8'(1 << $urandom_range(0, 7));
      else             v = 8'($urandom_range(0, 255));
      a_en  = ($urandom_range(0, 99) < 80);
      a_clr = ($urandom_range(0, 99) < 3);
      a_rst = ($urandom_range(0, 99) < 1);
      apply(a_rst, a_en, a_clr, v);
      checks++;
      if (pos !== 3'(m_pos) || pos_valid !== m_track || lap_count !== CNT_W'(m_lap) ||
          err_count !== CNT_W'(m_err) || err_onehot !== m_eoh || err_seq !== m_eseq) begin
        errors++;
        $display("FAIL random %0d: pos=%0d valid=%0b lap=%0d err=%0d eoh=%0b eseq=%0b expected %0d %0b %0d %0d %0b %0b",
                 n, pos, pos_valid, lap_count, err_count, err_onehot, err_seq,
                 m_pos, m_track, m_lap, m_err, m_eoh, m_eseq);
      end
      checks++;
      if (err_onehot === 1'b1 && err_seq === 1'b1) begin
        errors++;
        $display("FAIL random_exclusive %0d: eoh=1 eseq=1 expected at most one", n);
      end
    end
  endtask

  initial begin
    test_reset();
    test_full_lap();
    test_seq_err();
    test_onehot_err();
    test_stall();
    test_saturate();
    test_rst_priority();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
